matrix_row_store: RTL

//  Multi-bank complex-matrix row memory serving the LU, triangular-inverse and matrix-mul datapaths.

---
 rtl/matrix_row_store.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_row_store.sv
// matrix_row_store: shared multi-bank complex-matrix row memory.
// NUM_BANKS matrices of SIZE x SIZE elements, each element {imag,real} of 2*WIDTH bits.
// Ports: handshaked row read, row write, transposed column write, bank-clear engine.
// Optional build macro MATRIX_ROW_STORE_BYPASS_EN selects write-first reads
// (undefined: read-first).
module matrix_row_store #(
  parameter int SIZE      = 4,
  parameter int WIDTH     = 64,
  parameter int NUM_BANKS = 4,
  localparam int AW = $clog2(SIZE),
  localparam int BW = $clog2(NUM_BANKS),
  localparam int EW = 2 * WIDTH,
  localparam int RW = SIZE * EW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_req_i,
  input  logic [BW-1:0] rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_ready_o,
  output logic [RW-1:0] rd_row_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_valid_o,
  input  logic          rd_out_ready_i,
  input  logic          wr_row_valid_i,
  input  logic [BW-1:0] wr_row_bank_i,
  input  logic [AW-1:0] wr_row_addr_i,
  input  logic [RW-1:0] wr_row_i,
  input  logic          wr_col_valid_i,
  input  logic [BW-1:0] wr_col_bank_i,
  input  logic [AW-1:0] wr_col_addr_i,
  input  logic [RW-1:0] wr_col_i,
  output logic          wr_ready_o,
  input  logic          clr_i,
  input  logic [BW-1:0] clr_bank_i,
  output logic          busy_o
);

  localparam logic [AW-1:0] CNT_LAST = AW'(SIZE - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] clr_bank_q, clr_bank_d;

  logic [RW-1:0] mem_q [NUM_BANKS][SIZE];
  logic [RW-1:0] mem_d [NUM_BANKS][SIZE];

  logic          rd_valid_q, rd_valid_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic          rd_ready_s;
  logic          wr_ready_s;
  logic          clr_en_s;
  logic          rd_accept_s;
  logic [RW-1:0] rd_src_s;

  // FSM state register: mode, clear row counter and latched clear bank.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {AW{1'b0}};
      clr_bank_q <= {BW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_bank_q <= clr_bank_d;
    end
  end

  // FSM next state: IDLE starts a clear on clr_i; CLEAR walks rows 0..SIZE-1 then returns.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_bank_d = clr_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d    = ST_CLEAR;
          cnt_d      = {AW{1'b0}};
          clr_bank_d = clr_bank_i;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // FSM outputs: handshake readiness in IDLE, row zeroing in CLEAR.
  always_comb begin
    rd_ready_s = 1'b0;
    wr_ready_s = 1'b0;
    clr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ready_s = !rd_valid_q || rd_out_ready_i;
        wr_ready_s = 1'b1;
      end
      ST_CLEAR: begin
        clr_en_s = 1'b1;
      end
      default: begin
        clr_en_s = 1'b0;
      end
    endcase
  end

  // Storage next value: clear row, then column write, then row write so the row wins on overlap.
  always_comb begin
    mem_d = mem_q;
    // A reset edge aborts the clear without zeroing the row it lands on.
    if (clr_en_s && rst_ni) begin
      mem_d[clr_bank_q][cnt_q] = {RW{1'b0}};
    end else begin
      mem_d[clr_bank_q][cnt_q] = mem_q[clr_bank_q][cnt_q];
    end
    if (wr_ready_s && wr_col_valid_i) begin
      for (int i = 0; i < SIZE; i++) begin
        mem_d[wr_col_bank_i][AW'(i)][wr_col_addr_i*EW +: EW] = wr_col_i[i*EW +: EW];
      end
    end else begin
      mem_d[wr_col_bank_i][0] = mem_d[wr_col_bank_i][0];
    end
    if (wr_ready_s && wr_row_valid_i) begin
      mem_d[wr_row_bank_i][wr_row_addr_i] = wr_row_i;
    end else begin
      mem_d[wr_row_bank_i][wr_row_addr_i] = mem_d[wr_row_bank_i][wr_row_addr_i];
    end
  end

  // Storage array: contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef MATRIX_ROW_STORE_BYPASS_EN
  // Write-first: the read sees this cycle's merged writes.
  assign rd_src_s = mem_d[rd_bank_i][rd_addr_i];
`else
  // Read-first: the read sees the contents before this cycle's writes.
  assign rd_src_s = mem_q[rd_bank_i][rd_addr_i];
`endif

  assign rd_accept_s = rd_req_i && rd_ready_s;

  // Read output stage: load on accept, drop valid on consume, otherwise hold.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_row_d   = rd_row_q;
    rd_addr_d  = rd_addr_q;
    if (rd_accept_s) begin
      rd_valid_d = 1'b1;
      rd_row_d   = rd_src_s;
      rd_addr_d  = rd_addr_i;
    end else if (rd_valid_q && rd_out_ready_i) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // Read output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_row_q   <= {RW{1'b0}};
      rd_addr_q  <= {AW{1'b0}};
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_row_q   <= rd_row_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign rd_ready_o = rd_ready_s;
  assign wr_ready_o = wr_ready_s;
  assign rd_valid_o = rd_valid_q;
  assign rd_row_o   = rd_row_q;
  assign rd_addr_o  = rd_addr_q;
  assign busy_o     = (state_q == ST_CLEAR) || rd_valid_q;

endmodule
